// File: rtl/sha256_block_loader.sv
// Byte-stream front end for the single-block SHA-256 core: assembles the padded
// block, pulses the core reset, waits for completion and captures the digest.
module sha256_block_loader #(
  parameter int RST_CYCLES   = 4,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] core_block,
  output logic         core_rst,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         err
);

  localparam int TMAX = (RST_CYCLES > WAIT_TIMEOUT) ? RST_CYCLES : WAIT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PAD, S_START, S_WAIT, S_SETTLE, S_DONE, S_DRAIN
  } state_t;

  state_t        state, state_d;
  logic [5:0]    cnt;
  logic [TW-1:0] tmr;
  logic [8:0]    bpos;
  logic          accept, err_set, clr;

  assign in_ready     = ~reset & ((state == S_IDLE) | (state == S_DRAIN));
  assign core_rst     = ~reset & (state == S_START);
  assign busy         = (state != S_IDLE);
  assign digest_valid = (state == S_DONE);
  assign accept       = in_valid & in_ready;
  // Byte position cnt lives at the top of the block, first byte in [511:504].
  assign bpos         = 9'd511 - {cnt, 3'b000};
  assign clr          = err_set | (state == S_DONE);

  always_comb begin
    state_d = state;
    err_set = 1'b0;
    case (state)
      S_IDLE:
        if (accept) begin
          if (cnt == 6'd55) begin
            if (in_last) err_set = 1'b1;
            else         state_d = S_DRAIN;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      S_PAD:    state_d = S_START;
      S_START:  if (tmr == RST_LAST) state_d = S_WAIT;
      S_WAIT:
        if (core_ready) state_d = S_SETTLE;
        else if (tmr == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      S_SETTLE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_DRAIN:
        if (accept && in_last) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tmr        <= '0;
      core_block <= '0;
      digest     <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_d;
      err   <= err_set;

      // One timer serves both the reset pulse and the completion wait.
      if (clr || state_d != state) tmr <= '0;
      else if (state == S_START || state == S_WAIT) tmr <= tmr + 1'b1;

      if (clr) begin
        core_block <= '0;
        cnt        <= '0;
      end else if (state == S_IDLE && accept) begin
        core_block[bpos -: 8] <= in_data;
        cnt                   <= cnt + 6'd1;
      end else if (state == S_PAD) begin
        core_block[bpos -: 8] <= 8'h80;
        core_block[63:0]      <= {55'd0, cnt, 3'b000};
      end

      if (state == S_SETTLE) digest <= core_hash;
    end
  end

endmodule

// File: tb/tb_sha256_block_loader.sv
// Bench for sha256_block_loader: emulates the SHA-256 core with a software
// compression function and checks blocks, digests, timing and error paths.
module tb_sha256_block_loader;

  localparam int RST_CYCLES   = 4;
  localparam int WAIT_TIMEOUT = 255;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic         clk = 1'b0, reset = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0;
  logic         in_ready, core_rst, core_ready, digest_valid, busy, err;
  logic [511:0] core_block;
  logic [255:0] core_hash, digest;

  sha256_block_loader #(.RST_CYCLES(RST_CYCLES), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .core_block(core_block), .core_rst(core_rst), .core_ready(core_ready),
    .core_hash(core_hash), .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err));

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3]; e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H0[0], b + H0[1], c + H0[2], d + H0[3], e + H0[4], f + H0[5], g + H0[6], h + H0[7]};
  endfunction

  // Standard one-block padding: message, 0x80, zeros, 64-bit bit count.
  function automatic logic [511:0] pad_model(input logic [7:0] q[$]);
    logic [511:0] blk;
    blk = '0;
    foreach (q[i]) blk[511 - 8*i -: 8] = q[i];
    blk[511 - 8*q.size() -: 8] = 8'h80;
    blk[63:0] = 64'(q.size() * 8);
    return blk;
  endfunction

  // Core emulation: hash appears a configurable time after core_rst drops.
  int lat = 0;
  bit dead = 1'b0;
  bit armed;
  int ccnt;
  always @(posedge clk) begin
    if (reset) begin
      core_ready <= 1'b0; core_hash <= '0; armed <= 1'b0; ccnt <= 0;
    end else if (core_rst) begin
      core_ready <= 1'b0; armed <= 1'b1; ccnt <= 0;
    end else if (armed && !dead) begin
      if (ccnt >= lat) begin
        core_ready <= 1'b1; core_hash <= sha256(core_block); armed <= 1'b0;
      end else ccnt <= ccnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_hi = 0, dv_n = 0, err_n = 0, both_n = 0;
  int rst_rise = -1, rdy_rise = -1, dv_at = -1, err_at = -1;
  logic [511:0] blk_snap = '0;
  logic ir_at_rst = 1'b0, ir_at_err = 1'b0, prev_rst = 1'b0, prev_rdy = 1'b0;
  always @(negedge clk) begin
    prev_rst <= core_rst;
    prev_rdy <= core_ready;
    if (core_rst) rst_hi <= rst_hi + 1;
    if (core_rst && !prev_rst) begin rst_rise <= cyc; blk_snap <= core_block; ir_at_rst <= in_ready; end
    if (core_ready && !prev_rdy) rdy_rise <= cyc;
    if (digest_valid) begin dv_n <= dv_n + 1; dv_at <= cyc; end
    if (err) begin err_n <= err_n + 1; err_at <= cyc; ir_at_err <= in_ready; end
    if (err && digest_valid) both_n <= both_n + 1;
  end

  int nvec = 0, nmis = 0;
  logic [255:0] last_dig = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic str2q(input string s, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic send(input logic [7:0] q[$], input bit gaps, output int e, output logic busy_last);
    bit done;
    int g;
    e = -1; busy_last = 1'b0;
    foreach (q[i]) begin
      done = 1'b0; g = 0;
      while (!done && g < 200) begin
        tick(); g++;
        if (gaps && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        end else begin
          in_valid = 1'b1; in_data = q[i]; in_last = (i == q.size() - 1);
          done = in_ready;
          if (done && in_last) begin e = cyc; busy_last = busy; end
        end
      end
      if (!done) chk("send_stall", 0, 1);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic wait_done(input int dv0, input int er0, input int bound);
    int g;
    g = 0;
    while (dv_n == dv0 && err_n == er0 && g < bound) begin tick(); g++; end
    if (dv_n == dv0 && err_n == er0) chk("completion_timeout", 0, 1);
    tick(); tick();
  endtask

  task automatic run_good(input logic [7:0] q[$], input logic [255:0] known, input bit gaps);
    int dv0, er0, rh0, e;
    logic bl;
    logic [511:0] mb;
    logic [255:0] md;
    dv0 = dv_n; er0 = err_n; rh0 = rst_hi;
    mb = pad_model(q); md = sha256(mb);
    lat = $urandom_range(0, 15);
    send(q, gaps, e, bl);
    wait_done(dv0, er0, 1000);
    chk("block", blk_snap, mb);
    chk("digest", digest, md);
    if (known != 0) chk("digest_known", digest, known);
    chk("rst_cycles", rst_hi - rh0, RST_CYCLES);
    chk("dv_pulses", dv_n - dv0, 1);
    chk("err_pulses", err_n - er0, 0);
    chk("rst_start_cycle", rst_rise, e + 2);
    chk("dv_latency", dv_at, rdy_rise + 2);
    chk("in_ready_in_start", ir_at_rst, 0);
    last_dig = md;
  endtask

  task automatic run_err(input logic [7:0] q[$], input logic exp_busy);
    int dv0, er0, rh0, e;
    logic bl;
    dv0 = dv_n; er0 = err_n; rh0 = rst_hi;
    send(q, 1'b0, e, bl);
    wait_done(dv0, er0, 100);
    chk("ovf_err_pulses", err_n - er0, 1);
    chk("ovf_no_core_rst", rst_hi - rh0, 0);
    chk("ovf_no_dv", dv_n - dv0, 0);
    chk("ovf_digest_kept", digest, last_dig);
    chk("ovf_err_cycle", err_at, e + 1);
    chk("ovf_busy_last", bl, exp_busy);
    chk("ovf_ready_after", ir_at_err, 1);
  endtask

  typedef struct {
    string        msg;
    logic [255:0] dig;
    logic [31:0]  w0;
    logic [31:0]  wlen;
  } vec_t;

  initial begin
    vec_t tbl [3];
    logic [7:0] q[$];
    logic [511:0] b;
    int dv0, er0, rh0, e, g;
    logic bl;

    tbl[0] = '{"abc",   256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 32'h61626380, 32'h18};
    tbl[1] = '{"a",     256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb, 32'h61800000, 32'h08};
    tbl[2] = '{"hello", 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824, 32'h68656c6c, 32'h28};

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digest", digest, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_dv", digest_valid, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // Table vectors, back to back; "a" after "abc" must carry no residue.
    for (int i = 0; i < 3; i++) begin
      str2q(tbl[i].msg, q);
      run_good(q, tbl[i].dig, 1'b0);
      b = blk_snap;
      chk({"word0_", tbl[i].msg}, b[511:480], tbl[i].w0);
      chk({"wlen_", tbl[i].msg}, b[63:0], {32'd0, tbl[i].wlen});
      chk({"mid_zero_", tbl[i].msg}, b[447:64], 0);
    end

    // 55-byte single-block maximum.
    q.delete();
    repeat (55) q.push_back(8'h61);
    run_good(q, '0, 1'b1);
    b = blk_snap;
    chk("max_terminator", b[71:64], 8'h80);
    chk("max_length", b[63:0], 64'h1B8);

    // 56 bytes ending in last: immediate error; 60 bytes: drained then error.
    q.delete();
    repeat (56) q.push_back(8'($urandom));
    run_err(q, 1'b0);
    q.delete();
    repeat (60) q.push_back(8'($urandom));
    run_err(q, 1'b1);

    // Core never completes: timeout.
    dead = 1'b1;
    str2q("abc", q);
    dv0 = dv_n; er0 = err_n; rh0 = rst_hi;
    send(q, 1'b0, e, bl);
    wait_done(dv0, er0, 1000);
    chk("to_err_pulses", err_n - er0, 1);
    chk("to_no_dv", dv_n - dv0, 0);
    chk("to_rst_cycles", rst_hi - rh0, RST_CYCLES);
    chk("to_err_cycle", err_at, e + 2 + RST_CYCLES + WAIT_TIMEOUT);
    chk("to_ready_after", ir_at_err, 1);
    chk("to_digest_kept", digest, last_dig);
    dead = 1'b0;

    // Reset while the core reset pulse is active.
    str2q("abc", q);
    send(q, 1'b0, e, bl);
    g = 0;
    while (!core_rst && g < 20) begin tick(); g++; end
    chk("reach_start", core_rst, 1);
    reset = 1'b1;
    tick();
    chk("midrst_core_rst", core_rst, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_digest", digest, 0);
    chk("midrst_block", core_block, 0);
    reset = 1'b0;
    last_dig = '0;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    run_good(q, tbl[0].dig, 1'b0);

    // Random messages with input gaps and random core latency.
    for (int n = 0; n < 8; n++) begin
      q.delete();
      repeat ($urandom_range(1, 55)) q.push_back(8'($urandom));
      run_good(q, '0, 1'b1);
    end

    chk("err_dv_overlap", both_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
